// File: rtl/camara_sccb_config.sv
// Camera power-up sequencer and SCCB register writer for the Camara capture path.
// Build macro CAM_CFG_DELAY_EN: table entries with reg 8'hFE become idle delays.

module camara_sccb_config #(
    parameter int unsigned CLK_DIV   = 250,
    parameter logic [7:0]  DEV_ID    = 8'h42,
    parameter int unsigned RESET_CYC = 100000,
    parameter int unsigned BOOT_CYC  = 100000,
    parameter int unsigned GAP_CYC   = 1000,
    parameter int unsigned MS_CYC    = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe,
    output logic        cam_reset,
    output logic        cam_pwdn,
    output logic        busy,
    output logic        done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR,
        S_BOOT,
        S_FETCH,
        S_SAMPLE,
        S_START,
        S_SEND,
        S_STOP,
        S_GAP,
        S_DELAY,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       cnt, cnt_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [1:0]        qtr, qtr_nxt;
    logic [4:0]        bit_idx, bit_nxt;
    logic [15:0]       entry, entry_nxt;
    logic [7:0]        addr_nxt;
    logic              sioc_c, siod_c, oe_c;

    logic              tick, qtr_last, tbl_end, x_bit;
    logic [26:0]       frame;
    logic [31:0]       delay_cyc;
    state_t            adv_state;
    logic [7:0]        adv_addr;

    assign tick      = (div_cnt == DIV_LAST);
    assign qtr_last  = tick && (qtr == 2'd3);
    assign tbl_end   = (cfg_addr == 8'hFF);
    assign adv_state = tbl_end ? S_DONE : S_FETCH;
    assign adv_addr  = tbl_end ? cfg_addr : cfg_addr + 8'd1;
    assign frame     = {DEV_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
    assign x_bit     = (bit_idx == 5'd8) || (bit_idx == 5'd17)
                    || (bit_idx == 5'd26);
    assign delay_cyc = 32'(cfg_data[7:0]) * MS_CYC;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = '0;
        qtr_nxt   = qtr;
        bit_nxt   = bit_idx;
        entry_nxt = entry;
        addr_nxt  = cfg_addr;
        sioc_c    = 1'b1;
        siod_c    = 1'b1;
        oe_c      = 1'b1;

        // Quarter-bit timebase only runs while a frame is on the bus
        if (state inside {S_START, S_SEND, S_STOP}) begin
            if (tick) begin
                qtr_nxt = qtr + 2'd1;
            end else begin
                div_nxt = div_cnt + DIV_W'(1);
            end
        end

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_PWR;
                    cnt_nxt   = '0;
                    addr_nxt  = '0;
                end
            end
            S_PWR: begin
                if (cnt + 32'd1 >= RESET_CYC) begin
                    state_nxt = S_BOOT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            S_BOOT: begin
                if (cnt + 32'd1 >= BOOT_CYC) begin
                    state_nxt = S_FETCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            S_FETCH: begin
                state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                entry_nxt = cfg_data;
                qtr_nxt   = '0;
                bit_nxt   = '0;
                cnt_nxt   = delay_cyc;
                if (cfg_data == 16'hFFFF) begin
                    state_nxt = S_DONE;
`ifdef CAM_CFG_DELAY_EN
                end else if (cfg_data[15:8] == 8'hFE) begin
                    if (cfg_data[7:0] == 8'd0) begin
                        state_nxt = adv_state;
                        addr_nxt  = adv_addr;
                    end else begin
                        state_nxt = S_DELAY;
                    end
`endif
                end else begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                sioc_c = ~qtr[1];
                siod_c = (qtr == 2'd0);
                if (qtr_last) begin
                    state_nxt = S_SEND;
                    bit_nxt   = '0;
                end
            end
            S_SEND: begin
                sioc_c = (qtr == 2'd1) || (qtr == 2'd2);
                siod_c = x_bit ? 1'b1 : frame[5'd26 - bit_idx];
                oe_c   = ~x_bit;
                if (qtr_last) begin
                    if (bit_idx == 5'd26) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt = bit_idx + 5'd1;
                    end
                end
            end
            S_STOP: begin
                sioc_c = (qtr != 2'd0);
                siod_c = qtr[1];
                if (qtr_last) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end
            end
            S_GAP: begin
                if (cnt + 32'd1 >= GAP_CYC) begin
                    state_nxt = adv_state;
                    addr_nxt  = adv_addr;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            S_DELAY: begin
                if (cnt <= 32'd1) begin
                    state_nxt = adv_state;
                    addr_nxt  = adv_addr;
                end else begin
                    cnt_nxt = cnt - 32'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            div_cnt   <= '0;
            qtr       <= '0;
            bit_idx   <= '0;
            entry     <= '0;
            cfg_addr  <= '0;
            sioc      <= 1'b1;
            siod_o    <= 1'b1;
            siod_oe   <= 1'b1;
            cam_reset <= 1'b0;
            cam_pwdn  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div_cnt   <= div_nxt;
            qtr       <= qtr_nxt;
            bit_idx   <= bit_nxt;
            entry     <= entry_nxt;
            cfg_addr  <= addr_nxt;
            sioc      <= sioc_c;
            siod_o    <= siod_c;
            siod_oe   <= oe_c;
            // Pin/status flags track the state being entered, not the one left
            cam_reset <= !(state_nxt inside {S_IDLE, S_PWR});
            cam_pwdn  <= (state_nxt == S_IDLE);
            busy      <= !(state_nxt inside {S_IDLE, S_DONE});
            done      <= (state_nxt == S_DONE);
        end
    end

endmodule
